vissue_sched: RTL
=================

// Module: vissue_sched
// PURPOSE
//  In-order issue scheduler between the instruction-queue head and the vector functional units.
//  Each cycle it examines the oldest SLOTS queue entries and issues a contiguous oldest-first
//  prefix of them to free units. It returns per-slot pop strobes to the queue.
//  It tracks per-unit occupancy with countdown timers and honours flush and serialising instructions.
// PARAMETERS
//  SLOTS  2  queue-head entries examined (and max issues) per cycle
//  UNITS  4  functional units; UNIT_W = $clog2(UNITS), SLOT_W = $clog2(SLOTS) (min 1)
//  OCC_W  4  width of occupancy count; max unit blocking = 2**OCC_W-1 extra cycles
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous, active-high reset
//  flush        in   1               pipeline flush; kills this cycle's issue
//  head_valid   in   SLOTS           slot i holds a valid instruction (slot 0 = oldest)
//  head_unit    in   SLOTS x UNIT_W  target unit per slot
//  head_occ     in   SLOTS x OCC_W   extra cycles unit stays blocked after issue (0 = pipelined)
//  head_serial  in   SLOTS           instruction must issue alone with all units idle
//  unit_ready   in   UNITS           unit accepts an instruction this cycle
//  pop          out  SLOTS           slot i issued; remove from queue (contiguous from bit 0)
//  issue_valid  out  UNITS           instruction delivered to unit u this cycle
//  issue_slot   out  UNITS x SLOT_W  which head slot feeds unit u
//  unit_busy    out  UNITS           unit occupancy timer non-zero
//  stall_cnt    out  UNITS x 16      per-unit head-stall counters (see CONFIGURATION)
// BEHAVIOUR
//  - Zero-latency issue: pop/issue_valid/issue_slot are combinational from inputs + timers.
//  - free[u] = (timer[u]==0) & unit_ready[u].
//  - Slot i issues iff:
//    - head_valid[i], and every slot j<i issues;
//    - free[head_unit[i]], and no slot j<i targets the same unit this cycle;
//    - if head_serial[i]: i==0 and all timers 0; a serial slot 0 blocks slots >=1.
//  - Rule for slot i>0: stall if slot 0 is serial.
//  - pop is always a thermometer prefix; a blocked slot blocks all younger slots.
//  - issue_valid[u]=1 for the unit selected by an issuing slot; issue_slot[u] = that slot index.
//    - issue_slot = 0 when not issuing.
//  - Timer per unit:
//    - on issue, load head_occ of the issuing slot;
//    - else decrement if non-zero (saturate at 0).
//  - With occ=N the unit is next free N+1 cycles after issue.
//  - Flush: pop=0 and issue_valid=0 in the flush cycle; all timers cleared to 0 at the clock edge.
//  - Reset (rst=1): timers=0, stall counters=0; pop=0, issue_valid=0, issue_slot=0, unit_busy=0
//    while rst asserted.
//  - Reset/flush mid-occupancy: the unit is free the cycle after rst/flush deasserts.
//  - Simultaneous issue and unit_ready drop: the issue is not performed (unit_ready is sampled
//    the same cycle).
//  - Empty head (head_valid=0): pop=0, timers continue counting down.
// CONFIGURATION
//  VISSUE_STALL_CNT_EN defined:
//    - stall_cnt[u] increments (saturating at 16'hFFFF) each cycle slot 0 is valid, non-serial,
//      targets u, and is blocked by !free[u];
//    - counters cleared by rst only; not cleared by flush.
//  Undefined:
//    - counters not instantiated;
//    - stall_cnt tied to 0.
// STRUCTURE
//  Package vissue_pkg:
//    - unit_id_t (UNIT_W), occ_t (OCC_W), slot_id_t;
//    - head_entry_t struct {valid, unit, occ, serial};
//    - STALL_CNT_W=16.
//  Sub-module vissue_unit_timer (one per unit): load/decrement/clear counter, busy output.
//  Top: combinational in-order grant chain, per-unit one-hot claim mask, optional stall counters.
// TESTING
//  1. SLOTS=2, slot0 unit0 occ0, slot1 unit1 occ0, all ready
//     -> pop=2'b11, issue_valid=4'b0011, issue_slot[1]=1.
//  2. Both slots target unit2 -> pop=2'b01; the next cycle, with slot1 shifted to slot0, issues.
//  3. Issue unit1 occ=3 -> unit_busy[1] high 3 cycles; a unit1 instruction waiting at slot0 pops
//     in cycle 4 after issue.
//  4. slot0 serial with unit3 timer=2 -> pop=0 for 2 cycles, then pop=2'b01 with slot1 held.
//  5. flush asserted while unit0 timer=5 and head valid -> pop=0 that cycle;
//     unit_busy[0]=0 the next cycle.
//  6. With VISSUE_STALL_CNT_EN: hold slot0 on unit_ready[2]=0 for 10 cycles -> stall_cnt[2]=10;
//     rst mid-test -> 0.

Source files
------------

// File: rtl/vissue_pkg.sv
// Package for the vector issue scheduler.
// Holds the configuration constants, the scalar types for unit, slot and
// occupancy values, the head-entry record, and a saturating increment used by
// the optional per-unit stall counters.
package vissue_pkg;

    localparam int SLOTS       = 2;
    localparam int UNITS       = 4;
    localparam int OCC_W       = 4;
    localparam int UNIT_W      = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam int SLOT_W      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int STALL_CNT_W = 16;

    typedef logic [UNIT_W-1:0] unit_id_t;
    typedef logic [OCC_W-1:0]  occ_t;
    typedef logic [SLOT_W-1:0] slot_id_t;

    typedef struct packed {
        logic     valid;
        unit_id_t unit;
        occ_t     occ;
        logic     serial;
    } head_entry_t;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vissue_sched_if.sv
// Interface between the instruction-queue head, the issue scheduler and the
// vector functional units.
//   master : queue/unit side (drives head_*, unit_ready, flush; sees pop, issue_*, busy, stall_cnt)
//   slave  : the scheduler (the reverse directions)
interface vissue_sched_if;
    import vissue_pkg::*;

    logic                                   flush;
    logic [SLOTS-1:0]                       head_valid;
    unit_id_t [SLOTS-1:0]                   head_unit;
    occ_t [SLOTS-1:0]                       head_occ;
    logic [SLOTS-1:0]                       head_serial;
    logic [UNITS-1:0]                       unit_ready;
    logic [SLOTS-1:0]                       pop;
    logic [UNITS-1:0]                       issue_valid;
    slot_id_t [UNITS-1:0]                   issue_slot;
    logic [UNITS-1:0]                       unit_busy;
    logic [UNITS-1:0][STALL_CNT_W-1:0]      stall_cnt;

    modport master (
        output flush, head_valid, head_unit, head_occ, head_serial, unit_ready,
        input  pop, issue_valid, issue_slot, unit_busy, stall_cnt
    );

    modport slave (
        input  flush, head_valid, head_unit, head_occ, head_serial, unit_ready,
        output pop, issue_valid, issue_slot, unit_busy, stall_cnt
    );

endinterface

// File: rtl/vissue_unit_timer.sv
// Occupancy countdown timer for one functional unit.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : flush, zeroes the timer at the clock edge
//   load       : an instruction issues to this unit this cycle
//   load_val   : extra blocked cycles for the issued instruction
//   busy       : timer non-zero (unit cannot accept an instruction)
module vissue_unit_timer
    import vissue_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  occ_t load_val,
    output logic busy
);

    occ_t occ_d, occ_q;

    always_comb begin
        occ_d = occ_q;
        if (rst || clear) begin
            occ_d = '0;
        end else if (load) begin
            occ_d = load_val;
        end else if (occ_q != '0) begin
            occ_d = occ_q - occ_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        occ_q <= occ_d;
    end

    assign busy = (occ_q != '0);

endmodule

// File: rtl/vissue_sched.sv
// In-order issue scheduler between the instruction-queue head and the vector
// functional units. Each cycle the oldest SLOTS entries are examined and an
// oldest-first contiguous prefix is issued to free units, with zero latency.
//   clk, rst : clock, synchronous active-high reset
//   sif      : vissue_sched_if.slave (head entries, unit_ready, flush in;
//              pop, issue_valid, issue_slot, unit_busy, stall_cnt out)
// Optional feature: define VISSUE_STALL_CNT_EN to build per-unit saturating
// stall counters; otherwise stall_cnt is tied to zero.
module vissue_sched
    import vissue_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    vissue_sched_if.slave sif
);

    head_entry_t          head [SLOTS];
    logic [UNITS-1:0]     timer_busy;
    logic [UNITS-1:0]     free;
    logic [UNITS-1:0]     claim;
    occ_t [UNITS-1:0]     load_val;
    slot_id_t [UNITS-1:0] issue_slot;
    logic [SLOTS-1:0]     pop;
    logic                 all_idle;
    logic                 chain;
    logic                 ok;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            head[i].valid  = sif.head_valid[i];
            head[i].unit   = sif.head_unit[i];
            head[i].occ    = sif.head_occ[i];
            head[i].serial = sif.head_serial[i];
        end
    end

    assign free     = ~timer_busy & sif.unit_ready;
    assign all_idle = ~|timer_busy;

    // Grant chain: a slot issues only if every older slot issued, so a blocked
    // slot stops everything younger. claim doubles as the one-hot-per-unit
    // mask that keeps two slots off the same unit in one cycle.
    always_comb begin
        pop        = '0;
        claim      = '0;
        load_val   = '0;
        issue_slot = '0;
        chain      = !(rst || sif.flush);
        ok         = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            ok = chain && head[i].valid && free[head[i].unit] && !claim[head[i].unit];
            if (head[i].serial && (i != 0 || !all_idle)) ok = 1'b0;
            if (i != 0 && head[0].serial) ok = 1'b0;
            if (ok) begin
                pop[i]                     = 1'b1;
                claim[head[i].unit]        = 1'b1;
                load_val[head[i].unit]     = head[i].occ;
                issue_slot[head[i].unit]   = slot_id_t'(i);
            end
            chain = ok;
        end
    end

    for (genvar u = 0; u < UNITS; u++) begin : g_timer
        vissue_unit_timer u_timer (
            .clk      (clk),
            .rst      (rst),
            .clear    (sif.flush),
            .load     (claim[u]),
            .load_val (load_val[u]),
            .busy     (timer_busy[u])
        );
    end

    assign sif.pop         = pop;
    assign sif.issue_valid = claim;
    assign sif.issue_slot  = issue_slot;
    // Timers clear only at the edge; mask busy so it reads 0 throughout reset.
    assign sif.unit_busy   = timer_busy & {UNITS{~rst}};

`ifdef VISSUE_STALL_CNT_EN
    logic [UNITS-1:0][STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // Counts cycles the oldest entry waits on its unit; flush leaves it alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (rst) begin
            stall_cnt_d = '0;
        end else if (head[0].valid && !head[0].serial && !free[head[0].unit]) begin
            stall_cnt_d[head[0].unit] = sat_inc(stall_cnt_q[head[0].unit]);
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
    end

    assign sif.stall_cnt = stall_cnt_q;
`else
    assign sif.stall_cnt = '0;
`endif

endmodule
